nes_poll_scheduler: RTL
=======================

// Module: nes_poll_scheduler
// PURPOSE
//  Schedules and runs NES controller polls for two players sharing one latch/clock pair, with separate data lines.
//  Issues a poll every POLL_PERIOD_CYC cycles or on an external request, then shifts in 8 bits per player.
//  Publishes registered, active-high button bytes with press-edge pulses and a frame_valid strobe.
//  Sits between the GPIO controller pins and the game logic; replaces free-running per-controller readers.
// PARAMETERS
//  POLL_PERIOD_CYC  833333  cycles between scheduled polls (60 Hz at 50 MHz); must be > frame length
//  LATCH_CYC        600     latch high time in cycles (12 us at 50 MHz)
//  HALF_BIT_CYC     300     nes_clk half-period in cycles (6 us at 50 MHz)
// PORTS
//  clk          in   1  system clock (50 MHz)
//  reset_n      in   1  asynchronous, active-low reset
//  enable       in   1  1 = periodic polling active; 0 = no new scheduled polls
//  poll_req     in   1  single-cycle request for an immediate poll (honoured even when enable=0)
//  nes_data_p1  in   1  serial data from player 1 (low = pressed)
//  nes_data_p2  in   1  serial data from player 2 (low = pressed)
//  nes_latch    out  1  shared latch to both controllers
//  nes_clk      out  1  shared shift clock to both controllers
//  buttons_p1   out  8  P1 state, 1 = pressed: [7]A [6]B [5]select [4]start [3]up [2]down [1]left [0]right
//  buttons_p2   out  8  P2 state, same bit map
//  pressed_p1   out  8  1-cycle pulse per bit on the released->pressed transition (P1)
//  pressed_p2   out  8  1-cycle pulse per bit on the released->pressed transition (P2)
//  frame_valid  out  1  1-cycle pulse when buttons_* are updated
//  busy         out  1  1 while a poll frame is in progress (any state other than IDLE)
// BEHAVIOUR
//  - Reset (async, reset_n=0):
//    - all outputs are 0; nes_latch and nes_clk drop immediately.
//    - period counter, pending flag and shift registers are cleared; FSM goes to IDLE.
//  - Period counter:
//    - counts 0..POLL_PERIOD_CYC-1 while enable=1 and is held at 0 while enable=0.
//    - terminal count raises the pending flag.
//  - poll_req also raises the pending flag.
//  - Pending is a single flag: requests arriving while pending or busy merge into it; extra requests are dropped.
//  - FSM:
//    - IDLE: when pending=1, clear pending and go to LATCH on the next cycle.
//    - LATCH: nes_latch=1 for LATCH_CYC cycles, then go to LOW0.
//    - LOW0: nes_clk=0 for HALF_BIT_CYC cycles. On the last cycle, sample both data lines into bit 7.
//    - HIGH: nes_clk=1 for HALF_BIT_CYC cycles, then go to LOW.
//    - LOW: nes_clk=0 for HALF_BIT_CYC cycles. On the last cycle, sample the next bit (6 down to 0).
//      After bit 0 go to DONE; otherwise go back to HIGH.
//    - DONE: one cycle. Update buttons_* from the inverted shift data, pulse frame_valid,
//      drive pressed_* = new & ~old, then return to IDLE.
//  - Frame length is LATCH_CYC + 15*HALF_BIT_CYC + 2 cycles from leaving IDLE to returning to IDLE.
//  - nes_latch and nes_clk are registered outputs and never glitch.
//  - nes_latch and nes_clk are never both 1.
//  - enable falling mid-frame: the current frame completes normally; no further scheduled polls are issued.
//  - Terminal count coinciding with poll_req: a single poll results.
//  - A disconnected controller (data pulled high) reads as all released (0x00).
//  - pressed_* and frame_valid are 0 in every cycle other than DONE.
// CONFIGURATION
//  Macro NES_CONFIRM_EN controls a two-frame confirmation filter.
//  - Defined: each player's buttons_* update only when two consecutive frames return identical data
//    (a compare register is kept per player).
//    - frame_valid still pulses every frame.
//    - pressed_* reflect only confirmed changes.
//  - Not defined: buttons_* update on every frame, and no compare register is instantiated.
// STRUCTURE
//  - Shared header nes_defs.vh holds:
//    - button bit index localparams (NES_BIT_A=7 .. NES_BIT_RIGHT=0);
//    - FSM state encodings (IDLE, LATCH, LOW0, HIGH, LOW, DONE);
//    - default timing constants.
//  - One natural sub-module, nes_phase_timer: a loadable down-counter with a done flag, shared by LATCH/LOW0/HIGH/LOW.
//  - The two player shift registers stay in the top module.
// TESTING (sim params: POLL_PERIOD_CYC=200, LATCH_CYC=8, HALF_BIT_CYC=4 -> frame = 70 cycles)
//  1. Release reset with enable=1 and both data lines held 1.
//     -> First latch rises at cycle 200, nes_latch is high for 8 cycles, and there are 7 nes_clk high pulses of 4 cycles each.
//     -> frame_valid pulses once with buttons_p1=buttons_p2=0x00.
//  2. Model P1 pressing A and right (data pattern 0,1,1,1,1,1,1,0) and P2 pressing start.
//     -> buttons_p1=0x81 and buttons_p2=0x10.
//     -> pressed_p1=0x81 and pressed_p2=0x10 for exactly 1 cycle, together with frame_valid.
//  3. Keep the same pattern on the next frame -> buttons are unchanged and pressed_*=0x00.
//     Then release A -> buttons_p1=0x01 and pressed_p1=0x00.
//  4. Set enable=0 and pulse poll_req twice during a frame.
//     -> Exactly one extra frame follows the current one, and no periodic polls occur afterwards.
//  5. Assert reset_n=0 in the middle of HIGH.
//     -> nes_clk, nes_latch, busy and buttons_* go to 0 without waiting for clk.
//     -> After release, the first poll comes only at a period terminal count or on poll_req.
//  6. NES_CONFIRM_EN defined, single glitch frame on P1 (0xFF then 0x00).
//     -> buttons_p1 stays 0x00. Two identical frames of 0x40 -> buttons_p1=0x40 after the 2nd frame.

Source files
------------

// File: rtl/nes_poll_scheduler_pkg.sv
// Shared definitions for the NES poll scheduler: button bit map, FSM states,
// default timing and a counter-width helper.
package nes_poll_scheduler_pkg;

    localparam int NES_BIT_A      = 7;
    localparam int NES_BIT_B      = 6;
    localparam int NES_BIT_SELECT = 5;
    localparam int NES_BIT_START  = 4;
    localparam int NES_BIT_UP     = 3;
    localparam int NES_BIT_DOWN   = 2;
    localparam int NES_BIT_LEFT   = 1;
    localparam int NES_BIT_RIGHT  = 0;

    localparam int NES_POLL_PERIOD_DEF = 833333;
    localparam int NES_LATCH_DEF       = 600;
    localparam int NES_HALF_BIT_DEF    = 300;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_LOW0  = 3'd2,
        ST_HIGH  = 3'd3,
        ST_LOW   = 3'd4,
        ST_DONE  = 3'd5
    } nes_state_e;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int nes_cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/nes_phase_timer.sv
// Loadable down-counter timing one latch or half-bit phase; done_o is high
// while the count sits at zero, so loading N-1 gives an N-cycle phase.
module nes_phase_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/nes_poll_scheduler.sv
// Two-player NES controller poller on a shared latch/clock pair.
// Define NES_CONFIRM_EN to publish buttons only after two identical frames.
module nes_poll_scheduler
    import nes_poll_scheduler_pkg::*;
#(
    parameter int POLL_PERIOD_CYC = NES_POLL_PERIOD_DEF,
    parameter int LATCH_CYC       = NES_LATCH_DEF,
    parameter int HALF_BIT_CYC    = NES_HALF_BIT_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       poll_req,
    input  logic       nes_data_p1,
    input  logic       nes_data_p2,
    output logic       nes_latch,
    output logic       nes_clk,
    output logic [7:0] buttons_p1,
    output logic [7:0] buttons_p2,
    output logic [7:0] pressed_p1,
    output logic [7:0] pressed_p2,
    output logic       frame_valid,
    output logic       busy
);

    localparam int PW = nes_cnt_width(POLL_PERIOD_CYC - 1);
    localparam int TW = nes_cnt_width(((LATCH_CYC > HALF_BIT_CYC) ? LATCH_CYC : HALF_BIT_CYC) - 1);
    localparam logic [TW-1:0] LATCH_VAL = TW'(LATCH_CYC - 1);
    localparam logic [TW-1:0] HALF_VAL  = TW'(HALF_BIT_CYC - 1);

    nes_state_e    state_q;
    logic [PW-1:0] per_q, per_d;
    logic          pend_q, pend_d;
    logic          tc;
    logic [1:0]    sync1_q, sync2_q;
    logic          d1, d2;
    logic [6:0]    sr1_q, sr2_q;
    logic [2:0]    bit_q;
    logic          latch_q, nclk_q, fv_q;
    logic [7:0]    btn1_q, btn2_q, pr1_q, pr2_q;
    logic [7:0]    new1, new2;
    logic          upd1, upd2;
    logic          tmr_load, tmr_done;
    logic [TW-1:0] tmr_val;

    assign tc = enable && (per_q == PW'(POLL_PERIOD_CYC - 1));

    always_comb begin
        per_d = per_q + 1'b1;
        if (!enable || tc) begin
            per_d = '0;
        end
        // A request landing while IDLE consumes pending must survive.
        pend_d = (pend_q && (state_q != ST_IDLE)) || tc || poll_req;
    end

    assign d1   = sync1_q[1];
    assign d2   = sync2_q[1];
    assign new1 = ~{sr1_q, d1};
    assign new2 = ~{sr2_q, d2};

`ifdef NES_CONFIRM_EN
    logic [7:0] cmp1_q, cmp2_q;
    assign upd1 = (new1 == cmp1_q);
    assign upd2 = (new2 == cmp2_q);
`else
    assign upd1 = 1'b1;
    assign upd2 = 1'b1;
`endif

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = HALF_VAL;
        case (state_q)
            ST_IDLE: begin
                tmr_load = pend_q;
                tmr_val  = LATCH_VAL;
            end
            ST_LATCH, ST_LOW0, ST_HIGH: tmr_load = tmr_done;
            ST_LOW:  tmr_load = tmr_done && (bit_q != 3'd0);
            default: tmr_load = 1'b0;
        endcase
    end

    nes_phase_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst_n      (reset_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            per_q   <= '0;
            pend_q  <= 1'b0;
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            per_q   <= per_d;
            pend_q  <= pend_d;
            sync1_q <= {sync1_q[0], nes_data_p1};
            sync2_q <= {sync2_q[0], nes_data_p2};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            latch_q <= 1'b0;
            nclk_q  <= 1'b0;
            bit_q   <= 3'd0;
            sr1_q   <= '0;
            sr2_q   <= '0;
            btn1_q  <= '0;
            btn2_q  <= '0;
            pr1_q   <= '0;
            pr2_q   <= '0;
            fv_q    <= 1'b0;
`ifdef NES_CONFIRM_EN
            cmp1_q  <= '0;
            cmp2_q  <= '0;
`endif
        end else begin
            fv_q  <= 1'b0;
            pr1_q <= '0;
            pr2_q <= '0;
            case (state_q)
                ST_IDLE: if (pend_q) begin
                    state_q <= ST_LATCH;
                    latch_q <= 1'b1;
                end
                ST_LATCH: if (tmr_done) begin
                    state_q <= ST_LOW0;
                    latch_q <= 1'b0;
                end
                ST_LOW0: if (tmr_done) begin
                    state_q <= ST_HIGH;
                    nclk_q  <= 1'b1;
                    sr1_q   <= {sr1_q[5:0], d1};
                    sr2_q   <= {sr2_q[5:0], d2};
                    bit_q   <= 3'd6;
                end
                ST_HIGH: if (tmr_done) begin
                    state_q <= ST_LOW;
                    nclk_q  <= 1'b0;
                end
                ST_LOW: if (tmr_done) begin
                    if (bit_q == 3'd0) begin
                        // Publish on entry to DONE so the strobes are visible during DONE.
                        state_q <= ST_DONE;
                        fv_q    <= 1'b1;
                        if (upd1) begin
                            btn1_q <= new1;
                            pr1_q  <= new1 & ~btn1_q;
                        end
                        if (upd2) begin
                            btn2_q <= new2;
                            pr2_q  <= new2 & ~btn2_q;
                        end
`ifdef NES_CONFIRM_EN
                        cmp1_q <= new1;
                        cmp2_q <= new2;
`endif
                    end else begin
                        state_q <= ST_HIGH;
                        nclk_q  <= 1'b1;
                        sr1_q   <= {sr1_q[5:0], d1};
                        sr2_q   <= {sr2_q[5:0], d2};
                        bit_q   <= bit_q - 3'd1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign nes_latch   = latch_q;
    assign nes_clk     = nclk_q;
    assign buttons_p1  = btn1_q;
    assign buttons_p2  = btn2_q;
    assign pressed_p1  = pr1_q;
    assign pressed_p2  = pr2_q;
    assign frame_valid = fv_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
